// File: rtl/i2c_pkg.sv
// Shared types and sizes for the I2C target: FSM states, field widths
// and the encoding of the R/W bit that follows the 7-bit address.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    // Value of the eighth address-phase bit that selects a read transfer.
    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX_BYTE,
        TX_ACK,
        RX_BYTE,
        RX_ACK,
        WAIT_STOP
    } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes the scl/sda pair into the clk domain and produces one-clk
// strobes for scl edges and for START/STOP conditions. SYNC_STAGES >= 2.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Flops reset to 1 so an idle (pulled-up) bus produces no edge at reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o      = sda_s;
    assign scl_rise_o =  scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s &  scl_prev_q;
    // sda edges only count as bus conditions while scl stayed high across both samples.
    assign start_o    = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Single-register I2C target: address match with ACK, repeated transmit of
// 'mess' on reads, byte reception with ACK on writes. Never drives scl.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] mess,
    input  logic              scl,
    inout  wire               sda,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    logic              sda_s;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic              byte_done_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-2:0] tx_q;
    logic [DATA_W-2:0] tx_d;
    logic              rw_q;
    logic              nack_q;
    logic              sda_low_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    i2c_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_i     (scl),
        .sda_i     (sda),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_det),
        .stop_o    (stop_det)
    );

    assign shift_d = {shift_q[DATA_W-2:0], sda_s};
    // tx_q holds only the bits still to be sent; the bit on the wire lives in sda_low_q.
    assign tx_d    = {tx_q[DATA_W-3:0], 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            shift_q     <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            sda_low_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!en) begin
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                byte_done_q <= 1'b0;
                sda_low_q   <= 1'b0;
            end else if (start_det) begin
                state_q     <= ADDR;
                bit_cnt_q   <= '0;
                byte_done_q <= 1'b0;
                sda_low_q   <= 1'b0;
            end else if (stop_det) begin
                state_q     <= IDLE;
                byte_done_q <= 1'b0;
                sda_low_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ADDR, RX_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q <= 1'b1;
                            end
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            if (state_q == ADDR) begin
                                if (shift_q[DATA_W-1:1] == address) begin
                                    rw_q      <= shift_q[0];
                                    sda_low_q <= 1'b1;
                                    state_q   <= ADDR_ACK;
                                end else begin
                                    state_q   <= WAIT_STOP;
                                end
                            end else begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                                sda_low_q  <= 1'b1;
                                state_q    <= RX_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (rw_q == RW_READ) begin
                                tx_q      <= mess[DATA_W-2:0];
                                sda_low_q <= ~mess[DATA_W-1];
                                state_q   <= TX_BYTE;
                            end else begin
                                sda_low_q <= 1'b0;
                                state_q   <= RX_BYTE;
                            end
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                sda_low_q <= 1'b0;
                                state_q   <= TX_ACK;
                            end else begin
                                sda_low_q <= ~tx_q[DATA_W-2];
                                tx_q      <= tx_d;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            nack_q <= sda_s;
                        end else if (scl_fall) begin
                            if (!nack_q) begin
                                tx_q      <= mess[DATA_W-2:0];
                                sda_low_q <= ~mess[DATA_W-1];
                                bit_cnt_q <= '0;
                                state_q   <= TX_BYTE;
                            end else begin
                                state_q   <= WAIT_STOP;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            sda_low_q <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= RX_BYTE;
                        end
                    end
                    default: begin
                        sda_low_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Open-drain: only ever pull low, otherwise leave the bus to the pull-up.
    assign sda      = sda_low_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master plus a transaction-level
// model of what the target must answer, checked continuously and at each step.
`timescale 1ns/1ps
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic [6:0] address = 7'h70;
    logic [7:0] mess = 8'h0F;
    logic       scl_m = 1'b1;
    logic       sda_m_low = 1'b0;
    wire        sda_w;
    logic [7:0] rx_data;
    logic       rx_valid;

    assign sda_w = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave #(
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .address (address),
        .mess    (mess),
        .scl     (scl_m),
        .sda     (sda_w),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_rx = 8'h00;
    logic       quiet = 1'b0;
    logic       chk_on = 1'b0;
    logic       en_start = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Model: the target ACKs an address byte only if it was enabled when the
    // START happened, is still enabled, and the upper seven bits match.
    function automatic logic exp_ack(input logic [7:0] a);
        return (en_start && en && (a[7:1] == address)) ? 1'b0 : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (rx_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rx_valid_unexpected got=%0h want=none", rx_data);
                end else begin
                    model_rx = exp_q.pop_front();
                    if (rx_data !== model_rx) begin
                        bad++;
                        $display("FAIL rx_data_on_valid got=%0h want=%0h", rx_data, model_rx);
                    end
                end
            end else if (rx_data !== model_rx) begin
                bad++;
                $display("FAIL rx_data_hold got=%0h want=%0h", rx_data, model_rx);
            end
            if (quiet) begin
                total++;
                if (!sda_m_low && sda_w !== 1'b1) begin
                    bad++;
                    $display("FAIL slave_drove_sda got=%b want=1", sda_w);
                end
            end
        end
    end

    task automatic qtr();
        repeat (10) @(negedge clk);
    endtask

    task automatic start_c();
        en_start = en;
        sda_m_low = 1'b0; qtr();
        scl_m = 1'b1;     qtr();
        sda_m_low = 1'b1; qtr();
        scl_m = 1'b0;     qtr();
    endtask

    task automatic stop_c();
        sda_m_low = 1'b1; qtr();
        scl_m = 1'b1;     qtr();
        sda_m_low = 1'b0; qtr();
    endtask

    task automatic wbit(input logic b);
        sda_m_low = ~b; qtr();
        scl_m = 1'b1;   qtr(); qtr();
        scl_m = 1'b0;   qtr();
    endtask

    task automatic rbit(output logic b);
        sda_m_low = 1'b0; qtr();
        scl_m = 1'b1;     qtr();
        b = sda_w;        qtr();
        scl_m = 1'b0;     qtr();
    endtask

    task automatic wbyte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
    endtask

    task automatic rbyte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic       b;
        logic [7:0] d;
        logic [4:0] tail;

        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_sda", sda_w, 1'b1);
        reset_n = 1'b1;
        chk_on = 1'b1;
        qtr();

        // Read match: two bytes of mess, master ACKs the first, NACKs the second.
        start_c();
        wbyte(8'hE1);
        rbit(b);
        check("rd_addr_ack", b, exp_ack(8'hE1));
        check("rd_addr_ack_lit", b, 1'b0);
        rbyte(d);
        check("rd_byte0", d, mess);
        check("rd_byte0_lit", d, 8'h0F);
        wbit(1'b0);
        rbyte(d);
        check("rd_byte1", d, 8'h0F);
        wbit(1'b1);
        quiet = 1'b1;
        rbit(b);
        check("rd_release_after_nack", b, 1'b1);
        stop_c();
        qtr();
        rbit(b);
        check("idle_after_stop", b, 1'b1);
        quiet = 1'b0;

        // Write match: one data byte, ACKed, one rx_valid pulse.
        pulses = 0;
        exp_q.push_back(8'hF0);
        start_c();
        wbyte(8'hE0);
        rbit(b);
        check("wr_addr_ack", b, exp_ack(8'hE0));
        wbyte(8'hF0);
        rbit(b);
        check("wr_data_ack", b, 1'b0);
        stop_c();
        qtr();
        check("wr_rx_data", rx_data, 8'hF0);
        check("wr_pulses", pulses, 1);

        // Address mismatch: never driven until the next START.
        quiet = 1'b1;
        start_c();
        wbyte(8'hE2);
        rbit(b);
        check("mm_ack", b, exp_ack(8'hE2));
        check("mm_ack_lit", b, 1'b1);
        rbyte(d);
        check("mm_byte", d, 8'hFF);
        stop_c();
        qtr();

        // Disabled: a full read to our address stays untouched.
        en = 1'b0;
        start_c();
        wbyte(8'hE1);
        rbit(b);
        check("en0_ack", b, exp_ack(8'hE1));
        rbyte(d);
        check("en0_byte", d, 8'hFF);
        wbit(1'b1);
        stop_c();

        // Enabled mid-address: still idle until a fresh START.
        start_c();
        wbit(1'b1); wbit(1'b1); wbit(1'b1); wbit(1'b0);
        en = 1'b1;
        wbit(1'b0); wbit(1'b0); wbit(1'b0); wbit(1'b1);
        rbit(b);
        check("enmid_ack", b, exp_ack(8'hE1));
        rbyte(d);
        check("enmid_byte", d, 8'hFF);
        stop_c();
        qtr();
        quiet = 1'b0;

        // Repeated START: write address, then read address without STOP.
        mess = 8'hA5;
        start_c();
        wbyte(8'hE0);
        rbit(b);
        check("rs_wr_ack", b, exp_ack(8'hE0));
        start_c();
        wbyte(8'hE1);
        rbit(b);
        check("rs_rd_ack", b, 1'b0);
        rbyte(d);
        check("rs_byte", d, 8'hA5);
        wbit(1'b1);
        stop_c();
        qtr();

        // Reset while the target is pulling sda low in the middle of a byte.
        mess = 8'h0F;
        start_c();
        wbyte(8'hE1);
        rbit(b);
        check("rst_addr_ack", b, 1'b0);
        rbit(b);
        check("rst_bit7", b, 1'b0);
        rbit(b);
        check("rst_bit6", b, 1'b0);
        check("rst_pre_drive", sda_w, 1'b0);
        #2;
        reset_n = 1'b0;
        model_rx = 8'h00;
        quiet = 1'b1;
        #1;
        check("rst_sda_release", sda_w, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        qtr();
        reset_n = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            rbit(b);
            tail[i] = b;
        end
        check("rst_idle_tail", tail, 5'h1F);
        stop_c();
        qtr();
        quiet = 1'b0;

        check("rx_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
